// File: rtl/alu_iter_exec.sv
// alu_iter_exec: handshaked XLEN-wide execute unit.
// Base integer ops complete in one cycle; the M group (multiply/divide)
// runs iteratively over XLEN cycles. Illegal encodings are flagged and
// return a zero result. The result is held until the consumer accepts it.
// Optional feature macro: ALU_MULDIV_EN (defined: M group implemented,
// undefined: every muldiv request is reported illegal in one cycle).
module alu_iter_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  logic            muldiv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] op2_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] base_res_s;
    logic            base_ill_s;
    logic [XLEN-1:0] sra_s;

    assign op2_s   = use_imm ? imm : rs2;
    assign shamt_s = op2_s[SHW-1:0];
    assign sra_s   = $signed(rs1) >>> shamt_s;

    // Single-cycle base operations and their legality, keyed on {alt,funct3}
    always_comb begin
        base_res_s = {XLEN{1'b0}};
        base_ill_s = 1'b0;
        case ({alt, funct3})
            4'b0000: base_res_s = rs1 + op2_s;
            4'b1000: begin
                // SUB exists only in register form
                if (use_imm) begin
                    base_ill_s = 1'b1;
                end else begin
                    base_res_s = rs1 - op2_s;
                end
            end
            4'b0111: base_res_s = rs1 & op2_s;
            4'b0110: base_res_s = rs1 | op2_s;
            4'b0100: base_res_s = rs1 ^ op2_s;
            4'b0001: base_res_s = rs1 << shamt_s;
            4'b0101: base_res_s = rs1 >> shamt_s;
            4'b1101: base_res_s = sra_s;
            4'b0010: base_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(op2_s))};
            4'b0011: base_res_s = {{(XLEN-1){1'b0}}, (rs1 < op2_s)};
            default: base_ill_s = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // Shared iteration datapath: multiply keeps {hi,lo} product with the
    // multiplier shifting out of lo; divide keeps {remainder,quotient}.
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [2:0]        f_q, f_d;
    logic              neg_q, neg_d;

    logic              a_sgn_s, b_sgn_s, neg_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic              m_ill_s, early_s;
    logic [XLEN-1:0]   early_res_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_sh_s, div_diff_s;
    logic [2*XLEN-1:0] step_s;
    logic [XLEN-1:0]   hi_s, lo_s, mul_hi_neg_s, lo_neg_s, hi_neg_s;
    logic [XLEN-1:0]   final_s;

    // Decode M-group signedness, operand magnitudes and division early-outs
    always_comb begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_sgn_s = rs1[XLEN-1];
                b_sgn_s = rs2[XLEN-1];
            end
            3'b010:  a_sgn_s = rs1[XLEN-1];
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
        mag_a_s = a_sgn_s ? -rs1 : rs1;
        mag_b_s = b_sgn_s ? -rs2 : rs2;
        // Remainder follows the dividend; products and quotients follow both
        if (funct3[2] && funct3[1]) begin
            neg_s = a_sgn_s;
        end else begin
            neg_s = a_sgn_s ^ b_sgn_s;
        end
        m_ill_s     = alt | use_imm;
        early_s     = 1'b0;
        early_res_s = {XLEN{1'b0}};
        if (funct3[2]) begin
            if (rs2 == {XLEN{1'b0}}) begin
                early_s     = 1'b1;
                early_res_s = funct3[1] ? rs1 : {XLEN{1'b1}};
            end else if (!funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}})
                         && (rs2 == {XLEN{1'b1}})) begin
                early_s     = 1'b1;
                early_res_s = funct3[1] ? {XLEN{1'b0}} : rs1;
            end else begin
                early_s = 1'b0;
            end
        end else begin
            early_s = 1'b0;
        end
    end

    // One shift-add or restore-subtract step plus the final sign fix-up
    always_comb begin
        mul_sum_s  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        div_sh_s   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff_s = div_sh_s - {1'b0, mcand_q};
        if (f_q[2]) begin
            if (!div_diff_s[XLEN]) begin
                step_s = {div_diff_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
            end else begin
                step_s = {div_sh_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
            end
        end else begin
            if (prod_q[0]) begin
                step_s = {mul_sum_s, prod_q[XLEN-1:1]};
            end else begin
                step_s = {1'b0, prod_q[2*XLEN-1:1]};
            end
        end
        hi_s         = step_s[2*XLEN-1:XLEN];
        lo_s         = step_s[XLEN-1:0];
        // High half of the two's-complement negation of {hi,lo}
        mul_hi_neg_s = ~hi_s + {{(XLEN-1){1'b0}}, (lo_s == {XLEN{1'b0}})};
        lo_neg_s     = -lo_s;
        hi_neg_s     = -hi_s;
        case (f_q)
            3'b000:                 final_s = lo_s;
            3'b001, 3'b010, 3'b011: final_s = neg_q ? mul_hi_neg_s : hi_s;
            3'b100, 3'b101:         final_s = neg_q ? lo_neg_s : lo_s;
            3'b110, 3'b111:         final_s = neg_q ? hi_neg_s : hi_s;
            default:                final_s = {XLEN{1'b0}};
        endcase
    end

    // Iteration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q  <= {(2*XLEN){1'b0}};
            mcand_q <= {XLEN{1'b0}};
            cnt_q   <= {SHW{1'b0}};
            f_q     <= 3'd0;
            neg_q   <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            neg_q   <= neg_d;
        end
    end
`endif

    // Next-state, result capture and iteration control
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        f_d       = f_q;
        neg_d     = neg_q;
`endif
        if (flush) begin
            // Abort everything, including a same-cycle request
            state_d = S_IDLE;
`ifdef ALU_MULDIV_EN
            cnt_d   = {SHW{1'b0}};
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!muldiv) begin
                            result_d  = base_res_s;
                            illegal_d = base_ill_s;
                            state_d   = S_DONE;
                        end else begin
`ifdef ALU_MULDIV_EN
                            if (m_ill_s) begin
                                result_d  = {XLEN{1'b0}};
                                illegal_d = 1'b1;
                                state_d   = S_DONE;
                            end else if (early_s) begin
                                result_d  = early_res_s;
                                illegal_d = 1'b0;
                                state_d   = S_DONE;
                            end else begin
                                illegal_d = 1'b0;
                                f_d       = funct3;
                                neg_d     = neg_s;
                                cnt_d     = {SHW{1'b0}};
                                prod_d    = {{XLEN{1'b0}}, (funct3[2] ? mag_a_s : mag_b_s)};
                                mcand_d   = funct3[2] ? mag_b_s : mag_a_s;
                                state_d   = S_BUSY;
                            end
`else
                            result_d  = {XLEN{1'b0}};
                            illegal_d = 1'b1;
                            state_d   = S_DONE;
`endif
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
`ifdef ALU_MULDIV_EN
                    prod_d = step_s;
                    if (cnt_q == SHW'(XLEN-1)) begin
                        result_d = final_s;
                        cnt_d    = {SHW{1'b0}};
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = S_IDLE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control state and held result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= {XLEN{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Parametrised, handshaked execute unit; next generation of the single-cycle RV32I ALU.
- Generalised to XLEN. Single-cycle base integer ops. Iterative multi-cycle RV32M-style multiply/divide.
- Sits between decode/operand-select and writeback; holds its result until writeback accepts it.
- Flags illegal op encodings instead of leaving them undefined.

Parameters:
- XLEN, 32, datapath width. Power of two, ≥8. Shift amount is the low log2(XLEN) bits of op2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  abort any in-flight op, drop held result
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- rs1  in  XLEN  operand A
- rs2  in  XLEN  register operand B
- imm  in  XLEN  sign-extended immediate
- use_imm  in  1  1: op2=imm, 0: op2=rs2
- funct3  in  3  instruction funct3
- alt  in  1  funct7[5]; selects SUB/SRA
- muldiv  in  1  funct7[0]; selects M-extension group
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- illegal  out  1  qualifies result; op was undefined

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE, in_ready=1, out_valid=0, result=0, illegal=0, iteration counter=0. Applies mid-operation; the op is discarded.
- States and transitions:
  - IDLE: in_ready=1. A request is accepted on `in_valid & in_ready`. Base op or early-out goes to DONE. Mul/div goes to BUSY.
  - BUSY: in_ready=0. Counter runs 0..XLEN-1; at count XLEN-1 go to DONE.
  - DONE: out_valid=1. Goes to IDLE on `out_ready`. in_ready=0, so no skid.
- flush: highest priority after reset. Any state goes to IDLE next cycle, out_valid=0, no result delivered. Flush in the same cycle as an accept cancels the accept.
- Operands, funct3, alt, muldiv and use_imm are captured at accept. Later input changes are ignored.
- Latency, accept cycle N:
  - Base ops: out_valid at N+1.
  - MUL group: out_valid at N+XLEN+1 (radix-2 shift-add).
  - DIV group: out_valid at N+XLEN+1 (restoring division on magnitudes, sign fix in final cycle).
  - Early-outs: out_valid at N+1.
- result and illegal hold stable while out_valid=1 and out_ready=0.
- Base ops (muldiv=0), keyed on {alt,funct3}:
  - 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR
  - 0001 SLL, 0101 SRL, 1101 SRA (arithmetic; fills with rs1[XLEN-1])
  - 0010 SLT (signed), 0011 SLTU; result is 0 or 1 zero-extended
- alt=1 legality:
  - Legal only for SUB and SRA, and only with use_imm=0 for SUB.
  - SRAI is legal with use_imm=1.
  - Any other alt=1 combination: illegal=1, result=0, latency 1.
- Arithmetic wraps modulo 2^XLEN. No overflow flag.
- M group (muldiv=1, alt must be 0, use_imm must be 0, else illegal), keyed on funct3:
  - 000 MUL: low XLEN bits.
  - 001 MULH: signed×signed, high half.
  - 010 MULHSU: signed rs1 × unsigned rs2, high half.
  - 011 MULHU: unsigned×unsigned, high half.
  - 100 DIV, 101 DIVU: quotients truncate toward zero.
  - 110 REM: remainder sign follows dividend.
  - 111 REMU: unsigned remainder.
- Division early-outs, latency 1:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (rs1=most-negative, rs2=-1): DIV gives rs1; REM gives 0.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: M group implemented as above.
- Undefined: no multiplier/divider or BUSY datapath is synthesised. Any muldiv=1 request returns illegal=1, result=0, latency 1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-DIV → in_ready=1, out_valid=0, result=0 on the cycle after release.
- SUB, XLEN=32: rs1=5, rs2=7, use_imm=0, {alt,funct3}=1000 → result=0xFFFFFFFE one cycle after accept. SRAI: rs1=0x80000000, imm=4 → 0xF8000000.
- MULH: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result=0x00000000 at N+33. MULHU with the same operands → 0xFFFFFFFE.
- DIV: rs1=0xFFFFFFF9 (-7), rs2=2 → result=0xFFFFFFFD at N+33. REM with the same operands → 0xFFFFFFFF. DIVU with rs2=0 → 0xFFFFFFFF at N+1. DIV of 0x80000000 by 0xFFFFFFFF → 0x80000000 at N+1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result stable, in_ready=0; new in_valid is accepted only after the out_ready handshake.
- Flush at BUSY count 10 → out_valid never rises for that op; next ADD 1+1 returns 2 at N+1. Any alt=1 AND, or an M op with the macro undefined → illegal=1, result=0.
